// File: rtl/tt_sweep_pkg.sv
// Shared constants and types for the truth-table sweep engine.
package tt_sweep_pkg;

   // Number of inputs of the function under test.
   localparam int unsigned N_IN = 7;
   // Truth-table width, one bit per input vector.
   localparam int unsigned TT_W = 2 ** N_IN;
   // Width of the per-vector hold counter (SETTLE range 0..15).
   localparam int unsigned SETTLE_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StDone
   } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Per-vector hold counter for the sweep engine. sample_en_o marks the last
// hold cycle of the current vector, i.e. the cycle whose f_i gets captured.
module tt_settle_timer
   import tt_sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic sample_en_o
);

   localparam logic [SETTLE_W-1:0] HoldLast = SETTLE_W'(SETTLE);

   logic [SETTLE_W-1:0] hold_q, hold_d;

   // Count hold cycles; wrap to zero after the sampling cycle.
   always_comb begin
      hold_d = hold_q;
      if (clr_i) begin
         hold_d = '0;
      end else if (en_i) begin
         if (hold_q == HoldLast) begin
            hold_d = '0;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   // Hold counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign sample_en_o = en_i && (hold_q == HoldLast);

endmodule

// File: rtl/tt_sweep_engine.sv
// Truth-table sweep engine: drives every 7-bit vector into a combinational
// function, captures f_i per vector and assembles the 128-bit table.
// Optional feature macro: TT_SWEEP_COMPARE_EN (compare against expected_i).
module tt_sweep_engine
   import tt_sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   output logic [N_IN-1:0] x_o,
   input  logic            f_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [TT_W-1:0] tt_o,
   output logic            tt_valid_o,
   input  logic [TT_W-1:0] expected_i,
   output logic            mismatch_o,
   output logic [N_IN-1:0] first_mis_o
);

   state_e          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [N_IN-1:0] x_q, x_d;
   logic [TT_W-1:0] tt_q, tt_d;
   logic            tt_valid_q, tt_valid_d;

   logic start_acc;
   logic sample_en;
   logic last_vec;

   assign start_acc = (state_q == StIdle) && start_i;
   assign last_vec  = (idx_q == N_IN'(TT_W - 1));

   tt_settle_timer #(
      .SETTLE(SETTLE)
   ) u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (start_acc),
      .en_i       (state_q == StSweep),
      .sample_en_o(sample_en)
   );

   // FSM next state, index advance and table capture.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      x_d        = x_q;
      tt_d       = tt_q;
      tt_valid_d = tt_valid_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d    = StSweep;
               idx_d      = '0;
               x_d        = '0;
               tt_d       = '0;
               tt_valid_d = 1'b0;
            end
         end
         StSweep: begin
            if (sample_en) begin
               tt_d[idx_q] = f_i;
               if (last_vec) begin
                  // Table is complete on this edge, so valid rises with done_o.
                  state_d    = StDone;
                  tt_valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
                  x_d   = idx_q + 1'b1;
               end
            end
         end
         StDone: begin
            // idx wraps here; x_o keeps the last vector.
            state_d = StIdle;
            idx_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Main state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         x_q        <= '0;
         tt_q       <= '0;
         tt_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         x_q        <= x_d;
         tt_q       <= tt_d;
         tt_valid_q <= tt_valid_d;
      end
   end

   assign x_o        = x_q;
   assign busy_o     = (state_q == StSweep);
   assign done_o     = (state_q == StDone);
   assign tt_o       = tt_q;
   assign tt_valid_o = tt_valid_q;

`ifdef TT_SWEEP_COMPARE_EN
   logic [TT_W-1:0] exp_q, exp_d;
   logic            mis_q, mis_d;
   logic [N_IN-1:0] first_q, first_d;

   // Latch reference on start; record only the first mismatching index.
   always_comb begin
      exp_d   = exp_q;
      mis_d   = mis_q;
      first_d = first_q;
      if (start_acc) begin
         exp_d   = expected_i;
         mis_d   = 1'b0;
         first_d = '0;
      end else if ((state_q == StSweep) && sample_en && !mis_q &&
                   (f_i != exp_q[idx_q])) begin
         mis_d   = 1'b1;
         first_d = idx_q;
      end
   end

   // Compare registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q   <= '0;
         mis_q   <= 1'b0;
         first_q <= '0;
      end else begin
         exp_q   <= exp_d;
         mis_q   <= mis_d;
         first_q <= first_d;
      end
   end

   assign mismatch_o  = mis_q;
   assign first_mis_o = first_q;
`else
   logic unused_expected;
   assign unused_expected = ^expected_i;
   assign mismatch_o      = 1'b0;
   assign first_mis_o     = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_engine.sv
// Scoreboard bench for tt_sweep_engine: one instance with SETTLE=0 and one
// with SETTLE=3, each fed by a selectable bench-side function model.
module tb_tt_sweep_engine;

   typedef struct {
      logic [127:0] tt;
      logic         mis;
      logic [6:0]   first;
      int           lat;
   } exp_t;

`ifdef TT_SWEEP_COMPARE_EN
   localparam bit CmpEn = 1'b1;
`else
   localparam bit CmpEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start0 = 1'b0, start3 = 1'b0;
   logic [6:0]   x0, x3;
   logic         f0, f3;
   logic         busy0, busy3, done0, done3, val0, val3, mis0, mis3;
   logic [127:0] tt0, tt3;
   logic [6:0]   fm0, fm3;
   logic [127:0] exp_pat;
   int           mode0 = 0, mode3 = 0;
   int           cyc = 0;
   int           start_cyc0 = 0, start_cyc3 = 0;
   int           checks = 0, errors = 0;
   int           done_cnt0 = 0, done_cnt3 = 0;
   exp_t         q0[$];
   exp_t         q3[$];
   exp_t         e0, e3;

   logic [127:0] pat_zero, pat_x0, pat_maj, pat_x6, pat_bad;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic fmodel(int m, logic [6:0] x);
      logic maj;
      maj = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      case (m)
         1:       return x[0];
         2:       return maj;
         3:       return x[6];
         4:       return maj ^ (x == 7'd37);
         default: return 1'b0;
      endcase
   endfunction

   assign f0 = fmodel(mode0, x0);
   assign f3 = fmodel(mode3, x3);

   tt_sweep_engine #(.SETTLE(0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start0),
      .x_o        (x0),
      .f_i        (f0),
      .busy_o     (busy0),
      .done_o     (done0),
      .tt_o       (tt0),
      .tt_valid_o (val0),
      .expected_i (exp_pat),
      .mismatch_o (mis0),
      .first_mis_o(fm0)
   );

   tt_sweep_engine #(.SETTLE(3)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start3),
      .x_o        (x3),
      .f_i        (f3),
      .busy_o     (busy3),
      .done_o     (done3),
      .tt_o       (tt3),
      .tt_valid_o (val3),
      .expected_i (exp_pat),
      .mismatch_o (mis3),
      .first_mis_o(fm3)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitors: pop the expected result whenever a done_o pulse appears.
   always @(negedge clk) begin
      if (done0) begin
         done_cnt0++;
         if (q0.size() == 0) begin
            chk("dut0_unexpected_done", 128'(done_cnt0), 128'(0));
         end else begin
            e0 = q0.pop_front();
            chk("dut0_tt", tt0, e0.tt);
            chk("dut0_tt_valid", 128'(val0), 128'(1));
            chk("dut0_mismatch", 128'(mis0), 128'(e0.mis));
            chk("dut0_first_mis", 128'(fm0), 128'(e0.first));
            chk("dut0_latency", 128'(cyc - start_cyc0), 128'(e0.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (done3) begin
         done_cnt3++;
         if (q3.size() == 0) begin
            chk("dut3_unexpected_done", 128'(done_cnt3), 128'(0));
         end else begin
            e3 = q3.pop_front();
            chk("dut3_tt", tt3, e3.tt);
            chk("dut3_tt_valid", 128'(val3), 128'(1));
            chk("dut3_mismatch", 128'(mis3), 128'(e3.mis));
            chk("dut3_first_mis", 128'(fm3), 128'(e3.first));
            chk("dut3_latency", 128'(cyc - start_cyc3), 128'(e3.lat));
         end
      end
   end

   task automatic wait_done0(input int limit);
      int n = 0;
      while (!done0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("dut0_done_seen", 128'(done0), 128'(1));
   endtask

   task automatic wait_done3(input int limit);
      int n = 0;
      while (!done3 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("dut3_done_seen", 128'(done3), 128'(1));
   endtask

   // Full sweep on dut0, then step into IDLE ready for the next start.
   task automatic run0(input int m, input logic [127:0] tt, input logic mis,
                       input logic [6:0] first);
      exp_t e;
      e.tt = tt; e.mis = mis; e.first = first; e.lat = 129;
      mode0 = m;
      q0.push_back(e);
      start_cyc0 = cyc;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("dut0_busy_after_start", 128'(busy0), 128'(1));
      chk("dut0_x_first", 128'(x0), 128'(0));
      wait_done0(300);
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      pat_zero = '0;
      pat_x0   = {16{8'hAA}};
      pat_maj  = {16{8'hE8}};
      pat_x6   = {{64{1'b1}}, {64{1'b0}}};
      pat_bad  = pat_maj ^ (128'h1 << 37);
      exp_pat  = pat_maj;

      repeat (3) @(negedge clk);
      chk("rst_busy0", 128'(busy0), 128'(0));
      chk("rst_tt0", tt0, pat_zero);
      chk("rst_val0", 128'(val0), 128'(0));
      chk("rst_x3", 128'(x3), 128'(0));
      // start coincident with rst must be ignored.
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      rst = 1'b0;
      chk("rst_start_ignored", 128'(busy0), 128'(0));
      chk("rst_done0", 128'(done0), 128'(0));
      chk("rst_mis0", 128'(mis0), 128'(0));
      chk("rst_first0", 128'(fm0), 128'(0));
      while (cyc < 5) @(negedge clk);

      run0(0, pat_zero, 1'b0, 7'd0);
      run0(1, pat_x0, 1'b0, 7'd0);
      run0(2, pat_maj, 1'b0, 7'd0);
      run0(4, pat_bad, CmpEn, CmpEn ? 7'd37 : 7'd0);

      // SETTLE=3: each vector held four cycles, 513-cycle latency.
      e.tt = pat_x6; e.mis = 1'b0; e.first = 7'd0; e.lat = 513;
      mode3 = 3;
      q3.push_back(e);
      start_cyc3 = cyc;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("dut3_hold_x_k%0d", k), 128'(x3), 128'((k - 1) / 4));
         @(negedge clk);
      end
      wait_done3(700);
      @(negedge clk);

      // Reset mid-sweep at idx 60, then a fresh sweep from 0.
      mode0 = 1;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int n = 0; n < 200 && x0 != 7'd60; n++) @(negedge clk);
      chk("midrst_reached_60", 128'(x0), 128'(60));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 128'(busy0), 128'(0));
      chk("midrst_x", 128'(x0), 128'(0));
      chk("midrst_tt", tt0, pat_zero);
      chk("midrst_val", 128'(val0), 128'(0));
      @(negedge clk);
      run0(2, pat_maj, 1'b0, 7'd0);

      // start during SWEEP and during DONE is dropped.
      e.tt = pat_x0; e.mis = 1'b0; e.first = 7'd0; e.lat = 129;
      mode0 = 1;
      q0.push_back(e);
      start_cyc0 = cyc;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (10) @(negedge clk);
      chk("ign_busy_mid", 128'(busy0), 128'(1));
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done0(300);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("ign_idle_busy", 128'(busy0), 128'(0));
      chk("ign_x_hold", 128'(x0), 128'(127));
      chk("ign_val_hold", 128'(val0), 128'(1));
      repeat (150) @(negedge clk);
      chk("ign_still_idle", 128'(busy0), 128'(0));

      chk("q0_drained", 128'(q0.size()), 128'(0));
      chk("q3_drained", 128'(q3.size()), 128'(0));
      chk("done_cnt0", 128'(done_cnt0), 128'(6));
      chk("done_cnt3", 128'(done_cnt3), 128'(1));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_sweep_engine.md
# tt_sweep_engine

Sequential stimulus-and-capture stage for the 7-input classification flow. It sits directly upstream of a combinational 7-input function under test, driving every input vector x0..x6 into it in order. It captures the function's single-bit output for each vector and assembles the full 128-bit truth table. Downstream tooling uses that table as the function's identifier; the first-listed hex digit is the value for all-ones inputs.

## Interface
Parameters:
- N_IN, 7, number of function inputs; x_o bit k drives input xk.
- TT_W, 2**N_IN, truth-table width; derived, never overridden.
- SETTLE, 0, extra hold cycles per vector before sampling (0..15); covers multicycle paths through deep networks.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- x_o  out  N_IN  registered vector applied to the function under test.
- f_i  in  1  function output for the vector currently on x_o.
- busy_o  out  1  high in SWEEP.
- done_o  out  1  one-cycle pulse when the table is complete.
- tt_o  out  TT_W  captured truth table; bit i = f(x = i).
- tt_valid_o  out  1  high from done_o until the next accepted start_i or rst.
- expected_i  in  TT_W  reference table, sampled on accepted start_i (compare feature only).
- mismatch_o  out  1  table differs from expected (compare feature only).
- first_mis_o  out  N_IN  lowest mismatching index (compare feature only).

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE + start_i:
  - idx <= 0, hold <= 0, tt_o <= 0, tt_valid_o <= 0.
  - State <= SWEEP.
- SWEEP:
  - x_o = idx, registered.
  - If hold < SETTLE, hold increments.
  - Otherwise tt[idx] <= f_i and hold <= 0.
  - Then, if idx == TT_W-1, state <= DONE; else idx <= idx+1. idx wraps only through DONE, never within a sweep.
- DONE: done_o = 1 and tt_valid_o <= 1 for this one cycle; next state IDLE. x_o keeps its last value.
- start_i outside IDLE is ignored; it is not queued.
- start_i coincident with rst is ignored.
- rst in any state, including mid-sweep:
  - State IDLE; x_o, idx, hold, tt_o cleared.
  - busy_o, done_o, tt_valid_o, mismatch_o, first_mis_o all 0.
- Width rules: idx is N_IN bits; hold is 4 bits. f_i is treated as settled on the cycle it is sampled.

## Timing
- Reset values: all outputs 0.
- Start accepted at edge T: busy_o is high from T+1.
- x_o = 0 is valid from T+1; the first sample is taken at edge T+1+SETTLE.
- Each vector is held SETTLE+1 cycles.
- SWEEP lasts TT_W*(SETTLE+1) cycles; done_o asserts on the cycle that follows.
- Start-to-done latency: TT_W*(SETTLE+1)+1 cycles (129 with defaults).
- Earliest restart: start_i in the cycle after done_o (back in IDLE).

## Configuration
- TT_SWEEP_COMPARE_EN defined:
  - expected_i is latched on accepted start_i.
  - On each capture, if f_i != expected[idx] and mismatch_o == 0: mismatch_o <= 1, first_mis_o <= idx.
  - Both outputs are final at done_o and clear on the next accepted start_i or rst.
- TT_SWEEP_COMPARE_EN undefined:
  - No expected register or compare logic.
  - mismatch_o and first_mis_o tied to 0; expected_i unused.

## Structure
- Package tt_sweep_pkg holds:
  - N_IN and TT_W constants.
  - State enum type (IDLE, SWEEP, DONE).
  - SETTLE width constant.
- One sub-module, tt_settle_timer, owns the hold counter. Output: sample_en, high on the last hold cycle of each vector.
- The top-level owns the FSM, the index register, and tt/compare capture.

## Test plan
- Function f = 0, SETTLE = 0, start at cycle 5 -> done_o at cycle 134; tt_o = 0; tt_valid_o = 1.
- f = x0 -> tt_o = 0xAAAA…AA (32 hex digits). f = majority(x0,x1,x2) -> tt_o = 0xE8 repeated 16 times.
- SETTLE = 3 with f = x6 -> each x_o value held 4 cycles; done_o 513 cycles after start; tt_o = upper 64 bits 1, lower 64 bits 0.
- rst asserted while idx = 60 -> next cycle: IDLE, tt_o = 0, x_o = 0, busy_o = 0. A later start sweeps from idx 0.
- start_i pulsed while busy_o = 1 and again during DONE -> both ignored; exactly one done_o pulse per accepted start.
- Compare on, expected = 0xE8 pattern, f = majority but with bit 37 forced wrong -> mismatch_o = 1, first_mis_o = 37. With exact f -> mismatch_o = 0.
